// File: rtl/conv_host_mem.sv
// conv_host_mem: memory- and host-side partner of the convolution processor.
// Loads one raster image (IMG_W x IMG_H bytes) into 11 row banks round-robin
// and one 11x11 filter into a column store, pulses go, then captures the nine
// in-order pooled results and exposes them through a registered readback port.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     begin load/run (accepted in IDLE or DONE)
//   load_valid/load_data      byte stream in, load_ready = accept this cycle
//   go                        one-cycle processor start pulse
//   read0..read10 / mem0..10  per-bank read address / registered read data
//   readfilter / filter_col   filter column address / registered column data
//   write_out, out_addr_rr,
//   out_data                  processor result strobe, index and value
//   busy, done                status
//   res_rd_addr/res_rd_data   result readback address / registered data
module conv_host_mem #(
    parameter int IMG_W = 23,
    parameter int IMG_H = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    output logic        go,
    input  logic [7:0]  read0, read1, read2, read3, read4, read5,
    input  logic [7:0]  read6, read7, read8, read9, read10,
    input  logic [3:0]  readfilter,
    output logic [7:0]  mem0, mem1, mem2, mem3, mem4, mem5,
    output logic [7:0]  mem6, mem7, mem8, mem9, mem10,
    output logic [87:0] filter_col,
    input  logic        write_out,
    input  logic [3:0]  out_addr_rr,
    input  logic [22:0] out_data,
    output logic        busy,
    output logic        done,
    input  logic [3:0]  res_rd_addr,
    output logic [22:0] res_rd_data
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_IMG, S_LOAD_FLT, S_START, S_RUN, S_DONE
    } state_t;

    state_t state_q, state_d;

    // Storage arrays carry no reset; contents are only meaningful after a load.
    logic [7:0]  bank_mem [11][256];
    logic [87:0] filt_mem [11];
    logic [22:0] res_mem  [9];

    logic [7:0]  col_q, col_d, base_q, base_d;
    logic [15:0] row_q, row_d;
    logic [3:0]  bank_q, bank_d, fcol_q, fcol_d, flane_q, flane_d, exp_q, exp_d;

    logic [7:0]  rd_addr [11];
    logic [7:0]  mem_q   [11];
    logic [87:0] filter_q;
    logic [22:0] res_rd_q;

    logic accept, img_last, flt_last, cap;

    assign rd_addr[0] = read0;  assign rd_addr[1] = read1;  assign rd_addr[2]  = read2;
    assign rd_addr[3] = read3;  assign rd_addr[4] = read4;  assign rd_addr[5]  = read5;
    assign rd_addr[6] = read6;  assign rd_addr[7] = read7;  assign rd_addr[8]  = read8;
    assign rd_addr[9] = read9;  assign rd_addr[10] = read10;

    assign mem0 = mem_q[0];  assign mem1 = mem_q[1];  assign mem2  = mem_q[2];
    assign mem3 = mem_q[3];  assign mem4 = mem_q[4];  assign mem5  = mem_q[5];
    assign mem6 = mem_q[6];  assign mem7 = mem_q[7];  assign mem8  = mem_q[8];
    assign mem9 = mem_q[9];  assign mem10 = mem_q[10];
    assign filter_col  = filter_q;
    assign res_rd_data = res_rd_q;

    assign accept   = load_valid && load_ready;
    assign img_last = accept && (state_q == S_LOAD_IMG) &&
                      (col_q == 8'(IMG_W - 1)) && (row_q == 16'(IMG_H - 1));
    assign flt_last = accept && (state_q == S_LOAD_FLT) &&
                      (fcol_q == 4'd10) && (flane_q == 4'd10);
    // Only the expected index is taken, so a sticky strobe left at index 8
    // from an earlier run cannot be captured at the start of a new one.
    assign cap      = (state_q == S_RUN) && write_out && (out_addr_rr == exp_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start)    state_d = S_LOAD_IMG;
            S_LOAD_IMG: if (img_last) state_d = S_LOAD_FLT;
            S_LOAD_FLT: if (flt_last) state_d = S_START;
            S_START:                  state_d = S_RUN;
            S_RUN:      if (cap && (exp_q == 4'd8)) state_d = S_DONE;
            S_DONE:     if (start)    state_d = S_LOAD_IMG;
            default:                  state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        load_ready = 1'b0;
        go         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_LOAD_IMG, S_LOAD_FLT: begin load_ready = 1'b1; busy = 1'b1; end
            S_START:                begin go = 1'b1; busy = 1'b1; end
            S_RUN:                  busy = 1'b1;
            S_DONE:                 done = 1'b1;
            default:                ;
        endcase
    end

    // Load counters and result pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0; row_q <= '0; bank_q <= '0; base_q <= '0;
            fcol_q <= '0; flane_q <= '0; exp_q <= '0;
        end else begin
            col_q <= col_d; row_q <= row_d; bank_q <= bank_d; base_q <= base_d;
            fcol_q <= fcol_d; flane_q <= flane_d; exp_q <= exp_d;
        end
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        bank_d  = bank_q;
        base_d  = base_q;
        fcol_d  = fcol_q;
        flane_d = flane_q;
        exp_d   = exp_q;
        if (state_q == S_IDLE || state_q == S_DONE) begin
            // Parked states hold everything at zero so any start reloads cleanly.
            col_d = '0; row_d = '0; bank_d = '0; base_d = '0;
            fcol_d = '0; flane_d = '0; exp_d = '0;
        end else begin
            if (state_q == S_LOAD_IMG && accept) begin
                if (col_q == 8'(IMG_W - 1)) begin
                    col_d = '0;
                    row_d = row_q + 16'd1;
                    // Each full sweep of the 11 banks advances the in-bank row base.
                    if (bank_q == 4'd10) begin
                        bank_d = '0;
                        base_d = base_q + 8'(IMG_W);
                    end else begin
                        bank_d = bank_q + 4'd1;
                    end
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
            if (state_q == S_LOAD_FLT && accept) begin
                if (flane_q == 4'd10) begin
                    flane_d = '0;
                    fcol_d  = fcol_q + 4'd1;
                end else begin
                    flane_d = flane_q + 4'd1;
                end
            end
            if (state_q != S_RUN) exp_d = '0;
            else if (cap)         exp_d = exp_q + 4'd1;
        end
    end

    // Storage writes
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD_IMG && accept)
            bank_mem[bank_q][base_q + col_q] <= load_data;
        if (state_q == S_LOAD_FLT && accept)
            filt_mem[fcol_q][{flane_q, 3'b000} +: 8] <= load_data;
        if (cap)
            res_mem[exp_q] <= out_data;
    end

    // Registered read ports, served in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) mem_q[i] <= '0;
            filter_q <= '0;
            res_rd_q <= '0;
        end else begin
            for (int i = 0; i < 11; i++) mem_q[i] <= bank_mem[i][rd_addr[i]];
            filter_q <= (readfilter <= 4'd10) ? filt_mem[readfilter] : '0;
            res_rd_q <= (res_rd_addr <= 4'd8) ? res_mem[res_rd_addr] : '0;
        end
    end
endmodule

// File: tb/tb_conv_host_mem.sv
module tb_conv_host_mem;
    localparam int W = 23;
    localparam int H = 23;

    logic        clk = 1'b0;
    logic        rst, start, load_valid, load_ready, go, busy, done, write_out;
    logic [7:0]  load_data;
    logic [7:0]  rd    [11];
    logic [7:0]  mem_w [11];
    logic [3:0]  readfilter, out_addr_rr, res_rd_addr;
    logic [87:0] filter_col;
    logic [22:0] out_data, res_rd_data;

    always #5 clk = ~clk;

    conv_host_mem #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .go(go),
        .read0(rd[0]), .read1(rd[1]), .read2(rd[2]), .read3(rd[3]), .read4(rd[4]),
        .read5(rd[5]), .read6(rd[6]), .read7(rd[7]), .read8(rd[8]), .read9(rd[9]),
        .read10(rd[10]),
        .readfilter(readfilter),
        .mem0(mem_w[0]), .mem1(mem_w[1]), .mem2(mem_w[2]), .mem3(mem_w[3]),
        .mem4(mem_w[4]), .mem5(mem_w[5]), .mem6(mem_w[6]), .mem7(mem_w[7]),
        .mem8(mem_w[8]), .mem9(mem_w[9]), .mem10(mem_w[10]),
        .filter_col(filter_col),
        .write_out(write_out), .out_addr_rr(out_addr_rr), .out_data(out_data),
        .busy(busy), .done(done),
        .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data)
    );

    // kind 0: bank read (idx = bank), kind 1: filter read (lane checked)
    typedef struct {
        int    kind;
        int    idx;
        int    addr;
        int    lane;
        int    exp;
        bit    xr;     // expected value follows the loaded byte pattern
        string name;
    } vec_t;

    typedef struct {
        int    kind;
        int    idx;
        int    lane;
        int    exp;
        string name;
    } sb_t;

    typedef struct {
        int idx;
        int data;
    } res_t;

    vec_t vt[$];
    sb_t  rdq[$];
    res_t rq[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic vec_t mk(input int kind, input int idx, input int addr,
                                input int lane, input int exp, input bit xr,
                                input string name);
        vec_t v;
        v.kind = kind; v.idx = idx; v.addr = addr; v.lane = lane;
        v.exp = exp; v.xr = xr; v.name = name;
        return v;
    endfunction

    // Streams the image (byte = (r*W+c) mod 256) then the filter (byte = k),
    // each XORed with mask. Optional random bubbles on load_valid.
    task automatic load_all(input bit stalls, input logic [7:0] mask, output int bad);
        int v;
        bad = 0;
        for (int k = 0; k < W*H + 121; k++) begin
            if (stalls) begin
                while ($urandom_range(0, 3) == 0) begin
                    load_valid = 1'b0;
                    load_data  = 8'hEE;
                    @(negedge clk);
                end
            end
            if (!load_ready || !busy || go) bad++;
            v = (k < W*H) ? (k % 256) : (k - W*H);
            load_valid = 1'b1;
            load_data  = 8'(v) ^ mask;
            @(negedge clk);
        end
        load_valid = 1'b0;
    endtask

    // Issue one read per cycle; compare each against the scoreboard a cycle later.
    task automatic apply_table(input logic [7:0] mask);
        sb_t e, h;
        for (int i = 0; i <= vt.size(); i++) begin
            if (rdq.size() > 0) begin
                h = rdq.pop_front();
                if (h.kind == 0) check(h.name, mem_w[h.idx], h.exp);
                else             check(h.name, filter_col[h.lane*8 +: 8], h.exp);
            end
            for (int b = 0; b < 11; b++) rd[b] = 8'd0;
            readfilter = 4'd0;
            if (i < vt.size()) begin
                if (vt[i].kind == 0) rd[vt[i].idx] = 8'(vt[i].addr);
                else                 readfilter    = 4'(vt[i].addr);
                e.kind = vt[i].kind; e.idx = vt[i].idx; e.lane = vt[i].lane;
                e.exp  = vt[i].xr ? (vt[i].exp ^ int'(mask)) : vt[i].exp;
                e.name = vt[i].name;
                rdq.push_back(e);
            end
            @(negedge clk);
        end
    endtask

    task automatic drive_result(input int a, input int d, input bit expect_cap);
        res_t r;
        write_out   = 1'b1;
        out_addr_rr = 4'(a);
        out_data    = 23'(d);
        if (expect_cap) begin
            r.idx = a; r.data = d;
            rq.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic drain_results(input string tag);
        res_t r;
        while (rq.size() > 0) begin
            r = rq.pop_front();
            res_rd_addr = 4'(r.idx);
            @(negedge clk);
            check($sformatf("%s_res%0d", tag, r.idx), res_rd_data, r.data);
        end
    endtask

    initial begin
        int bad;

        vt.push_back(mk(0, 1, 23, 0, 20, 1, "bank1_a23"));
        vt.push_back(mk(0, 10, 22, 0, 252, 1, "bank10_a22"));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, "bank0_a0"));
        vt.push_back(mk(0, 0, 68, 0, 16, 1, "bank0_a68"));
        vt.push_back(mk(0, 5, 40, 0, 129, 1, "bank5_a40"));
        vt.push_back(mk(0, 10, 45, 0, 249, 1, "bank10_a45"));
        vt.push_back(mk(0, 0, 46, 0, 250, 1, "bank0_a46"));
        vt.push_back(mk(1, 0, 3, 0, 33, 1, "flt3_l0"));
        vt.push_back(mk(1, 0, 3, 10, 43, 1, "flt3_l10"));
        vt.push_back(mk(1, 0, 10, 10, 120, 1, "flt10_l10"));
        vt.push_back(mk(1, 0, 10, 0, 110, 1, "flt10_l0"));
        vt.push_back(mk(1, 0, 0, 4, 4, 1, "flt0_l4"));
        vt.push_back(mk(1, 0, 12, 0, 0, 0, "flt12_l0"));
        vt.push_back(mk(1, 0, 15, 5, 0, 0, "flt15_l5"));

        rst = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = 8'd0;
        write_out = 1'b0; out_addr_rr = 4'd0; out_data = 23'd0;
        readfilter = 4'd0; res_rd_addr = 4'd0;
        for (int b = 0; b < 11; b++) rd[b] = 8'd0;

        // Asynchronous reset asserted mid-cycle
        #13 rst = 1'b1;
        #1;
        check("rst_load_ready", load_ready, 0);
        check("rst_go", go, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem0", mem_w[0], 0);
        check("rst_mem10", mem_w[10], 0);
        check("rst_filter_col", filter_col, 0);
        check("rst_res_rd_data", res_rd_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // A byte offered in IDLE is not accepted
        load_valid = 1'b1; load_data = 8'h77;
        @(negedge clk);
        check("idle_load_ready", load_ready, 0);
        check("idle_busy", busy, 0);
        load_valid = 1'b0;

        // Run 1: continuous load with a stale sticky strobe at index 8
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        write_out = 1'b1; out_addr_rr = 4'd8; out_data = 23'd999;
        check("loadimg_busy", busy, 1);
        load_all(1'b0, 8'h00, bad);
        check("run1_load_bad_cycles", bad, 0);
        check("run1_go_high", go, 1);
        check("run1_start_ready", load_ready, 0);
        check("run1_start_busy", busy, 1);
        @(negedge clk);
        check("run1_go_low", go, 0);
        check("run1_run_busy", busy, 1);
        repeat (5) @(negedge clk);
        check("stale_no_done", done, 0);

        // start in RUN is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_run_busy", busy, 1);
        check("start_run_ready", load_ready, 0);

        apply_table(8'h00);

        for (int a = 0; a < 9; a++) begin
            if (a == 8) check("run1_done_before_last", done, 0);
            drive_result(a, 100 + a, 1'b1);
        end
        check("run1_done", done, 1);
        check("run1_done_busy", busy, 0);

        // Strobes in DONE are ignored
        out_addr_rr = 4'd0; out_data = 23'd555;
        repeat (2) @(negedge clk);
        write_out = 1'b0;
        drain_results("run1");
        res_rd_addr = 4'd9;
        @(negedge clk);
        check("readback_idx9", res_rd_data, 0);

        // Restart from DONE; results are retained until overwritten
        start = 1'b1;
        res_rd_addr = 4'd4;
        @(negedge clk);
        start = 1'b0;
        check("restart_done_low", done, 0);
        check("restart_busy", busy, 1);
        check("restart_ready", load_ready, 1);
        check("retained_res4", res_rd_data, 104);

        // Run 2: stalled load with a different byte pattern
        load_all(1'b1, 8'hA5, bad);
        check("run2_load_bad_cycles", bad, 0);
        check("run2_go_high", go, 1);
        @(negedge clk);
        apply_table(8'hA5);

        // Out-of-order index 2 after index 0 must be skipped
        drive_result(0, 200, 1'b1);
        drive_result(2, 777, 1'b0);
        for (int a = 1; a < 9; a++) begin
            if (a == 8) check("run2_done_before_last", done, 0);
            drive_result(a, 200 + a, 1'b1);
        end
        write_out = 1'b0;
        check("run2_done", done, 1);
        @(negedge clk);
        drain_results("run2");

        // Reset in the middle of a load
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load_valid = 1'b1;
        repeat (40) @(negedge clk);
        check("midload_busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        check("midload_rst_busy", busy, 0);
        check("midload_rst_ready", load_ready, 0);
        load_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_idle_done", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
